// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and inverse-cipher helper functions.
// Byte [i][j] of a state is row i, column j (FIPS-197 byte i+4j).
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [3:0][7:0]      word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam int NR = 10;

  // Entry 0 is unused; round r uses RCON[r].
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  // First literal is entry 0x00, so lookups index with the complemented byte.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[~b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    if (r <= 4'd10) begin
      return RCON[r];
    end else begin
      return 8'h00;
    end
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ x;
      end
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[i][j] = s[i][(j + 4 - i) % 4];
      end
    end
    return r;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t r;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        r[i][j] = gf_mul(s[i][j], 8'h0e) ^ gf_mul(s[(i + 1) % 4][j], 8'h0b) ^
                  gf_mul(s[(i + 2) % 4][j], 8'h0d) ^ gf_mul(s[(i + 3) % 4][j], 8'h09);
      end
    end
    return r;
  endfunction

  // Undo one key-expansion step: K(r) -> K(r-1).
  function automatic state_t inv_key_step(input state_t k, input logic [3:0] r);
    word_t  w0, w1, w2, w3, t;
    state_t res;
    for (int i = 0; i < 4; i++) begin
      w0[i] = k[i][0];
      w1[i] = k[i][1];
      w2[i] = k[i][2];
      w3[i] = k[i][3];
    end
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    for (int i = 0; i < 4; i++) begin
      t[i] = sbox(w3[(i + 1) % 4]);
    end
    t[0] = t[0] ^ rcon(r);
    w0 = w0 ^ t;
    for (int i = 0; i < 4; i++) begin
      res[i][0] = w0[i];
      res[i][1] = w1[i];
      res[i][2] = w2[i];
      res[i][3] = w3[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Ciphertext-in / plaintext-out valid-ready stream bundle for the iterative decryptor.
interface aes_decrypt_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_data;
  state_t in_key;
  logic   out_valid;
  logic   out_ready;
  state_t out_data;
  state_t out_key;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_key
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_key
  );

endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns except on the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t round_key_i,
  input  logic   last_i,
  output state_t state_o
);

  state_t shifted_s;
  state_t keyed_s;

  // Byte substitution and key addition ahead of the optional column mix.
  always_comb begin
    shifted_s = inv_shift_rows(state_i);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        keyed_s[i][j] = inv_sbox(shifted_s[i][j]) ^ round_key_i[i][j];
      end
    end
    if (last_i) begin
      state_o = keyed_s;
    end else begin
      state_o = inv_mix_columns(keyed_s);
    end
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys
// regenerated by running the key schedule backwards from the round-10 key.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_decrypt_iter_if.slave   bus
);

  fsm_e       state_q, state_d;
  state_t     st_q, st_d;
  state_t     rk_q, rk_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;

  state_t     key_prev_s;
  state_t     round_s;
  logic       last_s;
  logic       in_ready_s;
  logic       accept_s;

  assign key_prev_s = inv_key_step(rk_q, cnt_q);
  assign last_s     = (cnt_q == 4'd1);

  aes_inv_round u_round (
    .state_i     (st_q),
    .round_key_i (key_prev_s),
    .last_i      (last_s),
    .state_o     (round_s)
  );

  // A finished block can hand over to a new one in the same cycle.
  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = st_q;
  assign bus.out_key   = rk_q;

  // Next-state logic for the IDLE/ROUND/DONE sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          st_d    = bus.in_data ^ bus.in_key;
          rk_d    = bus.in_key;
          cnt_d   = 4'(NR);
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        st_d  = round_s;
        rk_d  = key_prev_s;
        cnt_d = cnt_q - 4'd1;
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = ROUND;
        end
      end
      DONE: begin
        if (accept_s) begin
          st_d    = bus.in_data ^ bus.in_key;
          rk_d    = bus.in_key;
          cnt_d   = 4'(NR);
          state_d = ROUND;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
